// File: rtl/icache_axi_refill_bridge.sv
// icache_axi_refill_bridge
//   Memory-side responder for the icache line-refill port. Takes one line read
//   request, issues a single AXI4 INCR burst (BEATS x DATA_WIDTH), packs the
//   returned beats into one line and hands it back with a one-cycle valid pulse.
//   Only one request is outstanding at a time.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | ready for a new line request; R channel not acknowledged
//   AR    | arvalid asserted with stable araddr, waiting for arready
//   RECV  | accepting R beats with matching rid into line slots
//   RET   | mem_return_en pulse; line data and error flag valid
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   icache_read_req/addr       line request (level) and byte address
//   mem_ready_to_read          bridge idle
//   mem_read_addr_ok           one-cycle accept pulse
//   mem_return_en/data/err     one-cycle line return, packed line, burst error
//   arid..arvalid, arready     AXI AR channel
//   rid..rvalid, rready        AXI R channel
module icache_axi_refill_bridge #(
   parameter int DATA_WIDTH = 32,
   parameter int BEATS      = 8,
   parameter int ID_WIDTH   = 4,
   parameter int ARID_VAL   = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         icache_read_req,
   input  logic [31:0]                  icache_read_addr,
   output logic                         mem_ready_to_read,
   output logic                         mem_read_addr_ok,
   output logic                         mem_return_en,
   output logic [DATA_WIDTH*BEATS-1:0]  mem_return_data,
   output logic                         mem_return_err,
   output logic [ID_WIDTH-1:0]          arid,
   output logic [31:0]                  araddr,
   output logic [7:0]                   arlen,
   output logic [2:0]                   arsize,
   output logic [1:0]                   arburst,
   output logic                         arvalid,
   input  logic                         arready,
   input  logic [ID_WIDTH-1:0]          rid,
   input  logic [DATA_WIDTH-1:0]        rdata,
   input  logic [1:0]                   rresp,
   input  logic                         rlast,
   input  logic                         rvalid,
   output logic                         rready
);

   localparam int LINE_WIDTH = DATA_WIDTH * BEATS;
   localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int OFF_W      = $clog2(LINE_WIDTH / 8);
   localparam logic [CNT_W-1:0]    LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic [31:0]         LINE_MASK = ~((32'd1 << OFF_W) - 32'd1);
   localparam logic [ID_WIDTH-1:0] ID_C      = ID_WIDTH'(ARID_VAL);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_AR   = 2'd1,
      ST_RECV = 2'd2,
      ST_RET  = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [31:0]            araddr_q, araddr_d;
   logic                   addr_ok_q, addr_ok_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   err_q, err_d;
   logic [LINE_WIDTH-1:0]  line_q, line_d;
   logic                   beat_fire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         araddr_q  <= '0;
         addr_ok_q <= 1'b0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         line_q    <= '0;
      end else begin
         state_q   <= state_d;
         araddr_q  <= araddr_d;
         addr_ok_q <= addr_ok_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         line_q    <= line_d;
      end
   end

   // Beats from another ID belong to someone else; they are never acknowledged.
   assign rready    = (state_q == ST_RECV) && (rid == ID_C);
   assign beat_fire = rready && rvalid;

   always_comb begin
      state_d   = state_q;
      araddr_d  = araddr_q;
      addr_ok_d = 1'b0;
      cnt_d     = cnt_q;
      err_d     = err_q;
      line_d    = line_q;
      case (state_q)
         ST_IDLE: begin
            if (icache_read_req) begin
               araddr_d  = icache_read_addr & LINE_MASK;
               addr_ok_d = 1'b1;
               state_d   = ST_AR;
            end
         end
         ST_AR: begin
            if (arready) state_d = ST_RECV;
         end
         ST_RECV: begin
            if (beat_fire) begin
               line_d[cnt_q*DATA_WIDTH +: DATA_WIDTH] = rdata;
               if (rresp != 2'b00) err_d = 1'b1;
               // rlast must appear exactly on the final beat
               if (rlast != (cnt_q == LAST_BEAT)) err_d = 1'b1;
               if (cnt_q == LAST_BEAT) state_d = ST_RET;
               else                    cnt_d   = cnt_q + 1'b1;
            end
         end
         ST_RET: begin
            state_d = ST_IDLE;
            err_d   = 1'b0;
            cnt_d   = '0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign mem_ready_to_read = (state_q == ST_IDLE);
   assign mem_read_addr_ok  = addr_ok_q;
   assign mem_return_en     = (state_q == ST_RET);
   assign mem_return_err    = (state_q == ST_RET) && err_q;
   assign mem_return_data   = line_q;

   assign arid    = ID_C;
   assign araddr  = araddr_q;
   assign arlen   = 8'(BEATS - 1);
   assign arsize  = 3'($clog2(DATA_WIDTH / 8));
   assign arburst = 2'b01;
   assign arvalid = (state_q == ST_AR);

endmodule

// File: tb/tb_icache_axi_refill_bridge.sv
module tb_icache_axi_refill_bridge;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          icache_read_req;
   logic [31:0]   icache_read_addr;
   logic          mem_ready_to_read, mem_read_addr_ok, mem_return_en, mem_return_err;
   logic [255:0]  mem_return_data;
   logic [3:0]    arid;
   logic [31:0]   araddr;
   logic [7:0]    arlen;
   logic [2:0]    arsize;
   logic [1:0]    arburst;
   logic          arvalid, arready;
   logic [3:0]    rid;
   logic [31:0]   rdata;
   logic [1:0]    rresp;
   logic          rlast, rvalid, rready;

   icache_axi_refill_bridge dut (
      .clk(clk), .rst_n(rst_n),
      .icache_read_req(icache_read_req), .icache_read_addr(icache_read_addr),
      .mem_ready_to_read(mem_ready_to_read), .mem_read_addr_ok(mem_read_addr_ok),
      .mem_return_en(mem_return_en), .mem_return_data(mem_return_data),
      .mem_return_err(mem_return_err),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
      .rready(rready)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;
   int n_ok    = 0;
   int n_ret   = 0;

   logic [31:0] beat_data [8];
   logic [1:0]  beat_resp [8];
   int          lastpos;

   always @(negedge clk) begin
      if (mem_read_addr_ok) n_ok++;
      if (mem_return_en)    n_ret++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"},   mem_ready_to_read, 1);
      chk({tag, "_addrok"},  mem_read_addr_ok, 0);
      chk({tag, "_reten"},   mem_return_en, 0);
      chk({tag, "_reterr"},  mem_return_err, 0);
      chk({tag, "_arvalid"}, arvalid, 0);
      chk({tag, "_rready"},  rready, 0);
      chk({tag, "_araddr"},  araddr, 0);
      chk({tag, "_data"},    mem_return_data, 0);
   endtask

   // gap_mode: 0 no gaps, 1 exactly one idle cycle before each beat, 2 random 0..2
   // Called at posedge+1 with the bridge idle.
   task automatic do_txn(input logic [31:0] addr, input int ar_stall, input int gap_mode,
                         input bit hold_req, input int abort_at, input bit junk);
      logic [255:0] exp_line;
      logic         exp_err;
      int           ok0, ret0, gaps;
      exp_line = '0;
      exp_err  = 1'b0;
      for (int i = 0; i < 8; i++) begin
         exp_line = exp_line | (256'(beat_data[i]) << (32 * i));
         if (beat_resp[i] != 2'b00) exp_err = 1'b1;
      end
      if (lastpos != 7) exp_err = 1'b1;
      ok0  = n_ok;
      ret0 = n_ret;

      chk("idle_ready", mem_ready_to_read, 1);
      icache_read_req  = 1'b1;
      icache_read_addr = addr;
      @(posedge clk); #1;
      chk("addr_ok",  mem_read_addr_ok, 1);
      chk("arvalid",  arvalid, 1);
      chk("araddr",   araddr, {addr[31:5], 5'b0});
      chk("arlen",    arlen, 7);
      chk("arsize",   arsize, 2);
      chk("arburst",  arburst, 1);
      chk("arid",     arid, 0);
      chk("busy",     mem_ready_to_read, 0);
      if (!hold_req) icache_read_req = 1'b0;

      for (int s = 0; s < ar_stall; s++) begin
         @(posedge clk); #1;
         chk("ar_hold_valid", arvalid, 1);
         chk("ar_hold_addr",  araddr, {addr[31:5], 5'b0});
         chk("ar_hold_ok",    mem_read_addr_ok, 0);
      end
      arready = 1'b1;
      @(posedge clk); #1;
      arready = 1'b0;
      chk("ar_done", arvalid, 0);

      for (int i = 0; i < 8; i++) begin
         gaps = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(2, 0));
         for (int g = 0; g < gaps; g++) begin
            rvalid = junk;
            rid    = junk ? 4'h5 : 4'h0;
            rdata  = $urandom;
            rresp  = 2'($urandom);
            rlast  = 1'($urandom);
            #1;
            if (junk) chk("junk_rready", rready, 0);
            @(posedge clk); #1;
         end
         if (i == abort_at) begin
            rst_n  = 1'b0;
            rvalid = 1'b0;
            #1;
            chk_reset_outputs("abort");
            rvalid = 1'b1;
            rid    = 4'h0;
            rdata  = 32'hDEAD_BEEF;
            rlast  = 1'b0;
            rresp  = 2'b00;
            #1;
            rst_n  = 1'b1;
            icache_read_req = 1'b0;
            chk("stray_rready", rready, 0);
            @(posedge clk); #1;
            chk_reset_outputs("post_abort");
            chk("abort_no_ret", n_ret - ret0, 0);
            rvalid = 1'b0;
            return;
         end
         rvalid = 1'b1;
         rid    = 4'h0;
         rdata  = beat_data[i];
         rresp  = beat_resp[i];
         rlast  = (i == lastpos);
         #1;
         chk("beat_rready", rready, 1);
         @(posedge clk); #1;
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;

      chk("ret_en",     mem_return_en, 1);
      chk("ret_data",   mem_return_data, exp_line);
      chk("ret_err",    mem_return_err, exp_err);
      chk("ret_rready", rready, 0);
      icache_read_req = 1'b0;
      @(posedge clk); #1;
      chk("ret_pulse",  mem_return_en, 0);
      chk("back_idle",  mem_ready_to_read, 1);
      chk("data_hold",  mem_return_data, exp_line);
      chk("err_clear",  mem_return_err, 0);
      chk("one_addr_ok", n_ok - ok0, 1);
      chk("one_return",  n_ret - ret0, 1);
   endtask

   task automatic set_ramp();
      for (int i = 0; i < 8; i++) begin
         beat_data[i] = 32'h1111_1111 * (i + 1);
         beat_resp[i] = 2'b00;
      end
      lastpos = 7;
   endtask

   initial begin
      rst_n = 1'b0;
      icache_read_req = 1'b0; icache_read_addr = '0;
      arready = 1'b0;
      rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
      #12;
      chk_reset_outputs("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      set_ramp();
      do_txn(32'h1C00_0014, 0, 0, 1'b0, -1, 1'b0);

      set_ramp();
      do_txn(32'h1C00_0014, 5, 1, 1'b0, -1, 1'b0);

      set_ramp();
      beat_resp[3] = 2'b10;
      do_txn(32'h0000_1234, 1, 0, 1'b0, -1, 1'b0);
      set_ramp();
      do_txn(32'h0000_1234, 0, 0, 1'b0, -1, 1'b0);

      set_ramp();
      lastpos = 5;
      do_txn(32'h8000_00FF, 2, 2, 1'b1, -1, 1'b0);

      set_ramp();
      do_txn(32'h4000_0040, 0, 0, 1'b0, 4, 1'b0);
      set_ramp();
      do_txn(32'h4000_0040, 0, 0, 1'b0, -1, 1'b0);

      for (int t = 0; t < 20; t++) begin
         for (int i = 0; i < 8; i++) begin
            beat_data[i] = $urandom;
            beat_resp[i] = ($urandom_range(15, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
         end
         lastpos = ($urandom_range(7, 0) == 0) ? int'($urandom_range(6, 0)) : 7;
         do_txn($urandom, int'($urandom_range(3, 0)), 2, 1'($urandom),
                -1, 1'($urandom));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
